// File: rtl/csa_sub_28bit_seq_if.sv
// Operand/result bundle for the sequential carry-select subtractor.
// The master drives the request and operands; the slave returns the handshake and the result.
interface csa_sub_28bit_seq_if #(
   parameter int unsigned WIDTH   = 28,
   parameter int unsigned B_WIDTH = 27
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [B_WIDTH-1:0] b;
   logic               b_in;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   diff;
   logic               b_out;

   modport master (
      output start, a, b, b_in,
      input  busy, done, diff, b_out
   );

   modport slave (
      input  start, a, b, b_in,
      output busy, done, diff, b_out
   );
endinterface

// File: rtl/csa_sub_28bit_seq.sv
// 28-bit subtractor diff = a - b - b_in, one carry-select segment (2,2,3,4,5,6,6 bits) per clock.
// Visible outputs update only when the last segment completes; a working register holds partials.
module csa_sub_28bit_seq #(
   parameter int unsigned WIDTH   = 28,
   parameter int unsigned B_WIDTH = 27
) (
   input  logic                  clk,
   input  logic                  rst,
   csa_sub_28bit_seq_if.slave    bus
);
   localparam int unsigned SEG_W   = 3;
   localparam int unsigned NSEG    = 7;
   localparam int unsigned SLICE_W = 6;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_n;
   logic [SEG_W-1:0]   seg, seg_n;
   logic [WIDTH-1:0]   a_r, a_n;
   logic [WIDTH-1:0]   b_r, b_n;
   logic [WIDTH-1:0]   work_r, work_n;
   logic [WIDTH-1:0]   diff_r, diff_n;
   logic               borrow_r, borrow_n;
   logic               b_out_r, b_out_n;
   logic               busy_r, busy_n;
   logic               done_r, done_n;

   logic [SLICE_W-1:0] a_s, b_s;
   logic [SLICE_W:0]   d0, d1, d_sel;
   logic [WIDTH-1:0]   work_ins;
   logic               seg_bo;

   // Operand slice for the current segment, zero-padded to the widest segment
   always_comb begin
      a_s = '0;
      b_s = '0;
      case (seg)
         3'd0: begin a_s = SLICE_W'(a_r[1:0]);   b_s = SLICE_W'(b_r[1:0]);   end
         3'd1: begin a_s = SLICE_W'(a_r[3:2]);   b_s = SLICE_W'(b_r[3:2]);   end
         3'd2: begin a_s = SLICE_W'(a_r[6:4]);   b_s = SLICE_W'(b_r[6:4]);   end
         3'd3: begin a_s = SLICE_W'(a_r[10:7]);  b_s = SLICE_W'(b_r[10:7]);  end
         3'd4: begin a_s = SLICE_W'(a_r[15:11]); b_s = SLICE_W'(b_r[15:11]); end
         3'd5: begin a_s = a_r[21:16];           b_s = b_r[21:16];           end
         3'd6: begin a_s = a_r[27:22];           b_s = b_r[27:22];           end
         default: begin a_s = '0; b_s = '0; end
      endcase
   end

   // Both borrow hypotheses, picked by the registered borrow from the segment below
   assign d0    = {1'b0, a_s} - {1'b0, b_s};
   assign d1    = d0 - (SLICE_W + 1)'(1);
   assign d_sel = borrow_r ? d1 : d0;

   // Merge the selected bits into the working result; the bit above the segment is its borrow out
   always_comb begin
      work_ins = work_r;
      seg_bo   = borrow_r;
      case (seg)
         3'd0: begin work_ins[1:0]   = d_sel[1:0]; seg_bo = d_sel[2]; end
         3'd1: begin work_ins[3:2]   = d_sel[1:0]; seg_bo = d_sel[2]; end
         3'd2: begin work_ins[6:4]   = d_sel[2:0]; seg_bo = d_sel[3]; end
         3'd3: begin work_ins[10:7]  = d_sel[3:0]; seg_bo = d_sel[4]; end
         3'd4: begin work_ins[15:11] = d_sel[4:0]; seg_bo = d_sel[5]; end
         3'd5: begin work_ins[21:16] = d_sel[5:0]; seg_bo = d_sel[6]; end
         3'd6: begin work_ins[27:22] = d_sel[5:0]; seg_bo = d_sel[6]; end
         default: begin work_ins = work_r; seg_bo = borrow_r; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         seg      <= '0;
         a_r      <= '0;
         b_r      <= '0;
         work_r   <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
         b_out_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state    <= state_n;
         seg      <= seg_n;
         a_r      <= a_n;
         b_r      <= b_n;
         work_r   <= work_n;
         diff_r   <= diff_n;
         borrow_r <= borrow_n;
         b_out_r  <= b_out_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      seg_n    = seg;
      a_n      = a_r;
      b_n      = b_r;
      work_n   = work_r;
      diff_n   = diff_r;
      borrow_n = borrow_r;
      b_out_n  = b_out_r;
      busy_n   = busy_r;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               a_n      = bus.a;
               b_n      = WIDTH'(bus.b);
               borrow_n = bus.b_in;
               work_n   = '0;
               seg_n    = '0;
               busy_n   = 1'b1;
               state_n  = RUN;
            end
         end
         RUN: begin
            work_n   = work_ins;
            borrow_n = seg_bo;
            seg_n    = seg + SEG_W'(1);
            if (seg == SEG_W'(NSEG - 1)) begin
               diff_n  = work_ins;
               b_out_n = seg_bo;
               done_n  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.diff  = diff_r;
   assign bus.b_out = b_out_r;
endmodule

// File: tb/tb_csa_sub_28bit_seq.sv
// Scoreboard bench for csa_sub_28bit_seq: expected results are queued on acceptance
// and compared when done pulses; latency, handshake and mid-run reset are also checked.
module tb_csa_sub_28bit_seq;
   localparam int unsigned WIDTH   = 28;
   localparam int unsigned B_WIDTH = 27;

   typedef struct packed {
      logic [WIDTH-1:0] diff;
      logic             b_out;
   } exp_t;

   logic clk;
   logic rst;
   csa_sub_28bit_seq_if #(.WIDTH(WIDTH), .B_WIDTH(B_WIDTH)) bus_if ();

   csa_sub_28bit_seq #(.WIDTH(WIDTH), .B_WIDTH(B_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   errors  = 0;
   int   checks  = 0;
   int   n_acc   = 0;
   int   n_done  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [B_WIDTH-1:0] b,
                                  input logic bin);
      logic [WIDTH:0] r;
      exp_t e;
      r = {1'b0, a} - {1'b0, WIDTH'(b)} - (WIDTH + 1)'(bin);
      e.diff  = r[WIDTH-1:0];
      e.b_out = r[WIDTH];
      return e;
   endfunction

   // Scoreboard consumer: every done pulse pops one expected result
   always @(negedge clk) begin
      if (!rst && bus_if.done) begin
         n_done++;
         if (sb_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("diff", 32'(bus_if.diff), 32'(e.diff));
            check("b_out", 32'(bus_if.b_out), 32'(e.b_out));
         end
      end
   end

   // Called just after a falling edge; returns one cycle after done, again just after a falling edge
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [B_WIDTH-1:0] b,
                         input logic bin, input bit hold, input bit check_lat);
      int  k;
      bit  got;
      bus_if.a     = a;
      bus_if.b     = b;
      bus_if.b_in  = bin;
      bus_if.start = 1'b1;
      @(negedge clk);
      check("accept_busy", 32'(bus_if.busy), 32'd1);
      sb_q.push_back(model(a, b, bin));
      n_acc++;
      if (!hold) bus_if.start = 1'b0;
      k   = 0;
      got = 1'b0;
      while (k < 20 && !got) begin
         if (hold) begin
            bus_if.a    = WIDTH'($urandom);
            bus_if.b    = B_WIDTH'($urandom);
            bus_if.b_in = 1'($urandom);
         end
         @(negedge clk);
         k++;
         if (bus_if.done) got = 1'b1;
      end
      if (!got) check("done_timeout", 32'd0, 32'd1);
      if (check_lat) check("latency", 32'(k), 32'd7);
      @(negedge clk);
      bus_if.start = 1'b0;
      if (check_lat) begin
         check("done_pulse_width", 32'(bus_if.done), 32'd0);
         check("busy_after_done", 32'(bus_if.busy), 32'd0);
      end
   endtask

   initial begin
      int done_snap;
      rst          = 1'b1;
      bus_if.start = 1'b0;
      bus_if.a     = '0;
      bus_if.b     = '0;
      bus_if.b_in  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_done", 32'(bus_if.done), 32'd0);
      check("rst_diff", 32'(bus_if.diff), 32'd0);
      check("rst_b_out", 32'(bus_if.b_out), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed corner cases
      run_op(28'h0000005, 27'd3, 1'b0, 1'b0, 1'b1);
      run_op(28'h0000000, 27'd1, 1'b0, 1'b0, 1'b1);
      run_op(28'h8000000, 27'h7FFFFFF, 1'b1, 1'b0, 1'b1);
      run_op(28'h0000000, 27'h7FFFFFF, 1'b1, 1'b0, 1'b1);
      run_op(28'hFFFFFFF, 27'h0000000, 1'b1, 1'b0, 1'b1);

      // Start held with changing operands through RUN and DONE, then an immediate follow-up
      run_op(28'h1234567, 27'h0765432, 1'b0, 1'b1, 1'b1);
      run_op(28'h0ABCDEF, 27'h0ABCDEF, 1'b1, 1'b0, 1'b1);

      // Abort in the third RUN cycle
      bus_if.a     = 28'h7654321;
      bus_if.b     = 27'h0000123;
      bus_if.b_in  = 1'b0;
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      check("abort_accept", 32'(bus_if.busy), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("abort_diff_before", 32'(bus_if.diff != '0), 32'd1);
      done_snap = n_done;
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus_if.busy), 32'd0);
      check("abort_done", 32'(bus_if.done), 32'd0);
      check("abort_diff", 32'(bus_if.diff), 32'd0);
      check("abort_b_out", 32'(bus_if.b_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_done", 32'(n_done), 32'(done_snap));
      run_op(28'h0000010, 27'h0000011, 1'b0, 1'b0, 1'b1);

      // Back-to-back random traffic with occasional extremes
      for (int i = 0; i < 1000; i++) begin
         logic [WIDTH-1:0]   ra;
         logic [B_WIDTH-1:0] rb;
         ra = WIDTH'($urandom);
         rb = B_WIDTH'($urandom);
         case ($urandom_range(0, 7))
            0: ra = '0;
            1: rb = '1;
            2: ra = '1;
            3: rb = B_WIDTH'(ra);
            default: ;
         endcase
         run_op(ra, rb, 1'($urandom), 1'b0, (i % 50) == 0);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(sb_q.size()), 32'd0);
      check("done_count", 32'(n_done), 32'(n_acc));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end
endmodule
